// File: rtl/doorbell_arbiter.sv
// Doorbell arbiter: latches trigger rising edges into sticky pending bits and
// presents them one at a time, round-robin, on a single acknowledged interrupt.
module doorbell_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 2,
  localparam int IDW       = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] db_trigger_i,
  input  logic [NUM_CH-1:0] db_mask_i,
  output logic              irq_o,
  output logic [IDW-1:0]    irq_id_o,
  input  logic              irq_ack_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] overrun_o,
  input  logic [NUM_CH-1:0] overrun_clr_i
);

  localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {IDLE, RING, GAP} state_t;

  state_t            state_q;
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] overrun_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    irq_id_q;
  logic              irq_q;
  logic [CW-1:0]     gap_q;

  logic [NUM_CH-1:0] edges;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] eligible;
  logic              ack_fire;
  logic [IDW-1:0]    winner;
  logic              found;
  logic [SW-1:0]     sum;
  logic [IDW-1:0]    idx;
  logic [IDW-1:0]    ptr_next;

  assign edges    = db_trigger_i & ~trig_q;
  assign ack_fire = (state_q == RING) && irq_ack_i;
  assign eligible = pending_q & ~db_mask_i;
  assign ptr_next = (irq_id_q == IDW'(NUM_CH - 1)) ? '0 : irq_id_q + 1'b1;

  always_comb begin
    clr = '0;
    if (ack_fire) clr[irq_id_q] = 1'b1;
  end

  // Scan from the round-robin pointer upward with wrap; first eligible wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NUM_CH)) sum = sum - SW'(NUM_CH);
      idx = sum[IDW-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      trig_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      irq_id_q  <= '0;
      irq_q     <= 1'b0;
      gap_q     <= '0;
    end else begin
      trig_q    <= db_trigger_i;
      pending_q <= (pending_q & ~clr) | edges;
      overrun_q <= (overrun_q & ~overrun_clr_i) | (edges & pending_q & ~clr);
      case (state_q)
        IDLE: begin
          if (found) begin
            irq_q    <= 1'b1;
            irq_id_q <= winner;
            state_q  <= RING;
          end
        end
        RING: begin
          if (irq_ack_i) begin
            irq_q <= 1'b0;
            ptr_q <= ptr_next;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
              gap_q   <= CW'(GAP_CYCLES);
            end
          end
        end
        GAP: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q <= CW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_o     = irq_q;
  assign irq_id_o  = irq_id_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule
